sparse_pos_encoder: RTL and testbench

- Upstream feeder for the sparse polynomial multiplier.
- Consumes a ternary sparse polynomial as a stream of N coefficients, one per handshake, and emits position words through the multiplier's position-RAM write port.
- Positions of +1 coefficients fill the first H/2 slots; positions of -1 coefficients fill the last H/2 slots. The multiplier derives each slot's sign from its index (slot < H/2 means positive).
- Packing is CORE_NUM positions per RAM word: word i = {pos[i*CORE_NUM+CORE_NUM-1], ..., pos[i*CORE_NUM+0]}, with the lowest slot in the LSBs.

---
 rtl/sparse_pos_encoder.sv | 202 ++++++++++++++++++++
 tb/tb_sparse_pos_encoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_pos_encoder.sv
// -----------------------------------------------------------------------------
// sparse_pos_encoder
// Front end of the sparse polynomial multiplier. It accepts a ternary sparse
// polynomial one coefficient per handshake and writes the coefficient positions
// into the multiplier's position RAM. Positions of +1 coefficients fill the
// first H/2 slots and positions of -1 coefficients fill the last H/2 slots.
// CORE_NUM positions are packed per RAM word, with the lowest slot in the LSBs.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse that begins an encode (ignored while busy)
//   in_valid/in_ready coefficient handshake
//   in_coeff          2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal
//   busy, done, err   status: busy in RUN/FIN, done pulse, sticky error
//   ram_pos_*         registered position-RAM write port
// -----------------------------------------------------------------------------
module sparse_pos_encoder #(
    parameter int unsigned N             = 512,
    parameter int unsigned H             = 256,
    parameter int unsigned CORE_NUM      = 2,
    parameter int unsigned POS_WIDTH     = $clog2(N),
    parameter int unsigned POS_RAM_DEPTH = H / CORE_NUM,
    parameter int unsigned POS_RAM_WIDTH = POS_WIDTH * CORE_NUM
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [1:0]                       in_coeff,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             ram_pos_wr_en,
    output logic [$clog2(POS_RAM_DEPTH)-1:0] ram_pos_wr_addr,
    output logic [POS_RAM_WIDTH-1:0]         ram_pos_data_in
);

    localparam int unsigned ADDR_W   = $clog2(POS_RAM_DEPTH);
    localparam int unsigned HALF     = H / 2;
    localparam int unsigned CNT_W    = $clog2(HALF + 1);
    localparam int unsigned NEG_BASE = HALF / CORE_NUM;

    localparam logic [1:0] COEFF_POS = 2'b01;
    localparam logic [1:0] COEFF_NEG = 2'b11;
    localparam logic [1:0] COEFF_BAD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [POS_WIDTH-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]         pos_cnt_q, pos_cnt_d;
    logic [CNT_W-1:0]         neg_cnt_q, neg_cnt_d;
    logic [POS_RAM_WIDTH-1:0] pos_pack_q, pos_pack_d;
    logic [POS_RAM_WIDTH-1:0] neg_pack_q, neg_pack_d;

    logic                     busy_d, done_d, err_d, in_ready_d;
    logic                     wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_d;
    logic [POS_RAM_WIDTH-1:0] wr_data_d;

    logic                     accept;
    logic [CNT_W-1:0]         pos_slot, neg_slot;
    logic [POS_RAM_WIDTH-1:0] pos_word, neg_word;

    // Next-state, counter, pack and output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pos_cnt_d  = pos_cnt_q;
        neg_cnt_d  = neg_cnt_q;
        pos_pack_d = pos_pack_q;
        neg_pack_d = neg_pack_q;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        in_ready_d = in_ready;
        wr_en_d    = 1'b0;
        wr_addr_d  = ram_pos_wr_addr;
        wr_data_d  = ram_pos_data_in;

        // Candidate words with the current index dropped into the next free slot
        pos_slot = CNT_W'(pos_cnt_q % CNT_W'(CORE_NUM));
        neg_slot = CNT_W'(neg_cnt_q % CNT_W'(CORE_NUM));
        pos_word = pos_pack_q;
        pos_word[pos_slot*POS_WIDTH +: POS_WIDTH] = idx_q;
        neg_word = neg_pack_q;
        neg_word[neg_slot*POS_WIDTH +: POS_WIDTH] = idx_q;

        accept = in_valid && in_ready && (state_q == S_RUN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = '0;
                    pos_cnt_d  = '0;
                    neg_cnt_d  = '0;
                    pos_pack_d = '0;
                    neg_pack_d = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    case (in_coeff)
                        COEFF_POS: begin
                            // A full positive half discards the position
                            if (pos_cnt_q == CNT_W'(HALF)) begin
                                err_d = 1'b1;
                            end else begin
                                pos_pack_d = pos_word;
                                pos_cnt_d  = pos_cnt_q + 1'b1;
                                if (pos_slot == CNT_W'(CORE_NUM - 1)) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = ADDR_W'(pos_cnt_q / CNT_W'(CORE_NUM));
                                    wr_data_d = pos_word;
                                end
                            end
                        end
                        COEFF_NEG: begin
                            if (neg_cnt_q == CNT_W'(HALF)) begin
                                err_d = 1'b1;
                            end else begin
                                neg_pack_d = neg_word;
                                neg_cnt_d  = neg_cnt_q + 1'b1;
                                if (neg_slot == CNT_W'(CORE_NUM - 1)) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = ADDR_W'(NEG_BASE)
                                              + ADDR_W'(neg_cnt_q / CNT_W'(CORE_NUM));
                                    wr_data_d = neg_word;
                                end
                            end
                        end
                        COEFF_BAD: err_d = 1'b1;
                        default:   ;
                    endcase
                    // idx holds at N-1 so it never wraps inside an encode
                    if (idx_q == POS_WIDTH'(N - 1)) begin
                        state_d    = S_FIN;
                        in_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if ((pos_cnt_q != CNT_W'(HALF)) || (neg_cnt_q != CNT_W'(HALF))) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            pos_cnt_q       <= '0;
            neg_cnt_q       <= '0;
            pos_pack_q      <= '0;
            neg_pack_q      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            in_ready        <= 1'b0;
            ram_pos_wr_en   <= 1'b0;
            ram_pos_wr_addr <= '0;
            ram_pos_data_in <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pos_cnt_q       <= pos_cnt_d;
            neg_cnt_q       <= neg_cnt_d;
            pos_pack_q      <= pos_pack_d;
            neg_pack_q      <= neg_pack_d;
            busy            <= busy_d;
            done            <= done_d;
            err             <= err_d;
            in_ready        <= in_ready_d;
            ram_pos_wr_en   <= wr_en_d;
            ram_pos_wr_addr <= wr_addr_d;
            ram_pos_data_in <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_sparse_pos_encoder.sv
// -----------------------------------------------------------------------------
// tb_sparse_pos_encoder
// Two encoder instances: a small one (N=16, H=4, CORE_NUM=2) for scenario and
// randomized streams, and a default-size one (N=512, H=256, CORE_NUM=2).
// Expected writes, error flags and timing come from a queue-based model of the
// position lists.
// -----------------------------------------------------------------------------
module tb_sparse_pos_encoder;

    localparam int A_N  = 16;
    localparam int A_H  = 4;
    localparam int A_C  = 2;
    localparam int A_PW = 4;
    localparam int B_N  = 512;
    localparam int B_PW = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Small instance
    logic       start_a, in_valid_a, in_ready_a, busy_a, done_a, err_a, wr_en_a;
    logic [1:0] in_coeff_a;
    logic [0:0] wr_addr_a;
    logic [7:0] wr_data_a;

    // Default-size instance
    logic        start_b, in_valid_b, in_ready_b, busy_b, done_b, err_b, wr_en_b;
    logic [1:0]  in_coeff_b;
    logic [6:0]  wr_addr_b;
    logic [17:0] wr_data_b;

    sparse_pos_encoder #(.N(A_N), .H(A_H), .CORE_NUM(A_C)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_coeff(in_coeff_a), .busy(busy_a), .done(done_a),
        .err(err_a), .ram_pos_wr_en(wr_en_a), .ram_pos_wr_addr(wr_addr_a),
        .ram_pos_data_in(wr_data_a)
    );

    sparse_pos_encoder u_dflt (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_coeff(in_coeff_b), .busy(busy_b), .done(done_b),
        .err(err_b), .ram_pos_wr_en(wr_en_b), .ram_pos_wr_addr(wr_addr_b),
        .ram_pos_data_in(wr_data_b)
    );

    int checks = 0;
    int fails  = 0;

    // Observations of one small-instance run
    int       acc_t [A_N];
    logic     err_acc [A_N];
    int       ow_t[$], ow_addr[$], ow_data[$];
    int       done_cnt, done_t, ready_viol;
    logic     err_done;
    logic [6:0] rst_snap;

    // Model results
    int   exp_addr[$], exp_data[$], exp_trig[$];
    logic exp_err_after [A_N];
    logic exp_err_done;

    logic [1:0] cf_w [A_N];

    // Reference model: ordered lists of +1 and -1 positions, packed CORE_NUM per word
    task automatic model_a(input logic [1:0] cf [A_N]);
        int   pl[$], nl[$];
        int   k, w;
        logic e;
        exp_addr.delete(); exp_data.delete(); exp_trig.delete();
        e = 1'b0;
        for (int i = 0; i < A_N; i++) begin
            if (cf[i] == 2'b01) begin
                if (pl.size() < A_H / 2) begin
                    pl.push_back(i);
                    if (pl.size() % A_C == 0) begin
                        k = pl.size() / A_C - 1;
                        w = 0;
                        for (int j = 0; j < A_C; j++) w |= pl[k*A_C+j] << (j*A_PW);
                        exp_addr.push_back(k); exp_data.push_back(w); exp_trig.push_back(i);
                    end
                end else e = 1'b1;
            end else if (cf[i] == 2'b11) begin
                if (nl.size() < A_H / 2) begin
                    nl.push_back(i);
                    if (nl.size() % A_C == 0) begin
                        k = nl.size() / A_C - 1;
                        w = 0;
                        for (int j = 0; j < A_C; j++) w |= nl[k*A_C+j] << (j*A_PW);
                        exp_addr.push_back(A_H / (2*A_C) + k); exp_data.push_back(w);
                        exp_trig.push_back(i);
                    end
                end else e = 1'b1;
            end else if (cf[i] == 2'b10) begin
                e = 1'b1;
            end
            exp_err_after[i] = e;
        end
        exp_err_done = e | (pl.size() != A_H / 2) | (nl.size() != A_H / 2);
    endtask

    // Drives one encode on the small instance and records what it produced.
    // restart_idx >= 0 pulses start again mid-RUN; rst_after > 0 resets after that many accepts.
    task automatic drive_a(input logic [1:0] cf [A_N], input int max_gap,
                           input int restart_idx, input int rst_after);
        int t, idx, gap, t_end;
        bit aborted, restarted;
        ow_t.delete(); ow_addr.delete(); ow_data.delete();
        done_cnt = 0; done_t = -1; err_done = 1'b0; ready_viol = 0; rst_snap = '1;
        for (int i = 0; i < A_N; i++) begin acc_t[i] = -1; err_acc[i] = 1'bx; end
        @(negedge clk);
        if (in_ready_a) ready_viol++;
        t = 0; idx = 0; gap = 0; t_end = 400; aborted = 0; restarted = 0;
        start_a = 1'b1;
        in_valid_a = 1'b1;      // valid while IDLE must not be accepted
        in_coeff_a = cf[0];
        while (t < t_end) begin
            @(negedge clk);
            t++;
            start_a = 1'b0;
            if (wr_en_a) begin
                ow_t.push_back(t); ow_addr.push_back(int'(wr_addr_a));
                ow_data.push_back(int'(wr_data_a));
            end
            if (done_a) begin done_cnt++; done_t = t; err_done = err_a; end
            if (idx > 0 && acc_t[idx-1] == t) err_acc[idx-1] = err_a;
            if (idx == A_N && in_ready_a) ready_viol++;
            if (!aborted && rst_after > 0 && idx == rst_after && acc_t[idx-1] == t) begin
                rst_n = 1'b0;
                #1;
                rst_snap = {busy_a, done_a, err_a, in_ready_a, wr_en_a, |wr_addr_a, |wr_data_a};
                aborted = 1; t_end = t + 4; in_valid_a = 1'b0;
            end
            if (aborted) begin
                if (t == t_end - 2) rst_n = 1'b1;
                continue;
            end
            if (idx < A_N) begin
                if (idx == restart_idx && !restarted) begin start_a = 1'b1; restarted = 1; end
                if (gap > 0) begin
                    in_valid_a = 1'b0; in_coeff_a = 2'($urandom); gap--;
                end else begin
                    in_valid_a = 1'b1; in_coeff_a = cf[idx];
                end
                if (in_valid_a && in_ready_a) begin
                    acc_t[idx] = t + 1;
                    idx++;
                    gap = $urandom_range(0, max_gap);
                    if (idx == A_N) t_end = t + 5;
                end
            end else begin
                // Valid in FIN/IDLE must be ignored
                in_valid_a = 1'($urandom); in_coeff_a = 2'($urandom);
            end
        end
        in_valid_a = 1'b0; start_a = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_coeff_a = 2'b00; in_coeff_b = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a, in_ready_a, wr_en_a, wr_addr_a, wr_data_a} !== '0) begin
            fails++;
            $display("FAIL reset_small: busy=%b done=%b err=%b rdy=%b we=%b addr=%h data=%h, required all 0",
                     busy_a, done_a, err_a, in_ready_a, wr_en_a, wr_addr_a, wr_data_a);
        end
        checks++;
        if ({busy_b, done_b, err_b, in_ready_b, wr_en_b, wr_addr_b, wr_data_b} !== '0) begin
            fails++;
            $display("FAIL reset_dflt: busy=%b done=%b err=%b rdy=%b we=%b addr=%h data=%h, required all 0",
                     busy_b, done_b, err_b, in_ready_b, wr_en_b, wr_addr_b, wr_data_b);
        end
        // start held during reset must not launch an encode
        start_a = 1'b0; start_b = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_wins: busy_a=%b busy_b=%b, required 0", busy_a, busy_b);
        end
    endtask

    task automatic test_stream(input logic [1:0] cf [A_N], input int max_gap,
                               input int restart_idx, input string tag);
        int n;
        model_a(cf);
        drive_a(cf, max_gap, restart_idx, 0);
        checks++;
        if (acc_t[A_N-1] < 0) begin
            fails++;
            $display("FAIL %s accepts: last accept never seen, required %0d accepts", tag, A_N);
        end
        checks++;
        if (ow_t.size() != exp_addr.size()) begin
            fails++;
            $display("FAIL %s write_count: got %0d, required %0d", tag, ow_t.size(), exp_addr.size());
        end
        n = (ow_t.size() < exp_addr.size()) ? ow_t.size() : exp_addr.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ow_addr[k] != exp_addr[k] || ow_data[k] != exp_data[k] ||
                ow_t[k] != acc_t[exp_trig[k]]) begin
                fails++;
                $display("FAIL %s write%0d: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                         tag, k, ow_addr[k], ow_data[k], ow_t[k], exp_addr[k], exp_data[k],
                         acc_t[exp_trig[k]]);
            end
        end
        for (int i = 0; i < A_N; i++) begin
            checks++;
            if (err_acc[i] !== exp_err_after[i]) begin
                fails++;
                $display("FAIL %s err_after_idx%0d: got %b, required %b", tag, i, err_acc[i],
                         exp_err_after[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_t != acc_t[A_N-1] + 1) begin
            fails++;
            $display("FAIL %s done: count=%0d cyc=%0d, required count=1 cyc=%0d", tag, done_cnt,
                     done_t, acc_t[A_N-1] + 1);
        end
        checks++;
        if (err_done !== exp_err_done) begin
            fails++;
            $display("FAIL %s err_at_done: got %b, required %b", tag, err_done, exp_err_done);
        end
        checks++;
        if (ready_viol != 0) begin
            fails++;
            $display("FAIL %s in_ready_outside_run: %0d cycles, required 0", tag, ready_viol);
        end
    endtask

    task automatic test_random_patterns();
        logic [1:0] cf [A_N];
        int perm [A_N];
        int j, tmp;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < A_N; i++) begin perm[i] = i; cf[i] = 2'b00; end
            for (int i = A_N - 1; i > 0; i--) begin
                j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            cf[perm[0]] = 2'b01; cf[perm[1]] = 2'b01;
            cf[perm[2]] = 2'b11; cf[perm[3]] = 2'b11;
            if (r == 4) cf[perm[4]] = 2'(($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            test_stream(cf, 3, -1, "random");
        end
    endtask

    task automatic test_reset_mid(input logic [1:0] cf [A_N]);
        drive_a(cf, 0, -1, 7);
        checks++;
        if (rst_snap !== 7'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: {busy,done,err,rdy,we,addr,data}=%b, required 0", rst_snap);
        end
        checks++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL reset_mid_done: %0d pulses, required 0", done_cnt);
        end
    endtask

    task automatic test_default_config();
        logic [1:0] cf [B_N];
        int pl[$], nl[$];
        int obs [128];
        int exp_w [128];
        int wcnt, dup, dcnt, dt, stall, t, last_t;
        logic derr;
        for (int i = 0; i < B_N; i++) begin
            cf[i] = (i < 256) ? ((i % 2 == 0) ? 2'b01 : 2'b11) : 2'b00;
            if (cf[i] == 2'b01) pl.push_back(i);
            if (cf[i] == 2'b11) nl.push_back(i);
        end
        for (int k = 0; k < 64; k++) begin
            exp_w[k]      = (pl[2*k+1] << B_PW) | pl[2*k];
            exp_w[64 + k] = (nl[2*k+1] << B_PW) | nl[2*k];
            obs[k] = -1; obs[64 + k] = -1;
        end
        wcnt = 0; dup = 0; dcnt = 0; dt = -1; stall = 0; derr = 1'b0; t = 0; last_t = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < B_N + 6; i++) begin
            if (i < B_N) begin
                in_valid_b = 1'b1; in_coeff_b = cf[i];
                if (!in_ready_b) stall++;
                if (i == B_N - 1) last_t = t + 1;
            end else begin
                in_valid_b = 1'b0;
            end
            @(negedge clk);
            t++;
            if (wr_en_b) begin
                wcnt++;
                if (obs[wr_addr_b] != -1) dup++;
                obs[wr_addr_b] = int'(wr_data_b);
            end
            if (done_b) begin dcnt++; dt = t; derr = err_b; end
        end
        checks++;
        if (wcnt != 128 || dup != 0 || stall != 0) begin
            fails++;
            $display("FAIL dflt_writes: count=%0d dup=%0d stalls=%0d, required 128/0/0", wcnt, dup, stall);
        end
        for (int k = 0; k < 128; k++) begin
            checks++;
            if (obs[k] != exp_w[k]) begin
                fails++;
                $display("FAIL dflt_word%0d: got %h, required %h", k, obs[k], exp_w[k]);
            end
        end
        checks++;
        if (obs[0] != ((2 << 9) | 0) || obs[63] != ((254 << 9) | 252) ||
            obs[64] != ((3 << 9) | 1) || obs[127] != ((255 << 9) | 253)) begin
            fails++;
            $display("FAIL dflt_corners: %h %h %h %h, required %h %h %h %h", obs[0], obs[63],
                     obs[64], obs[127], (2 << 9), (254 << 9) | 252, (3 << 9) | 1, (255 << 9) | 253);
        end
        checks++;
        if (dcnt != 1 || dt != last_t + 1 || derr !== 1'b0) begin
            fails++;
            $display("FAIL dflt_done: count=%0d cyc=%0d err=%b, required 1 cyc=%0d err=0",
                     dcnt, dt, derr, last_t + 1);
        end
    endtask

    initial begin
        test_reset();

        for (int i = 0; i < A_N; i++) cf_w[i] = 2'b00;
        cf_w[3] = 2'b01; cf_w[9] = 2'b01; cf_w[5] = 2'b11; cf_w[12] = 2'b11;
        test_stream(cf_w, 0, -1, "basic");
        test_stream(cf_w, 3, -1, "gaps");
        test_stream(cf_w, 0, 6, "restart_ignored");
        test_reset_mid(cf_w);
        test_stream(cf_w, 0, -1, "after_reset");

        cf_w[14] = 2'b01;
        test_stream(cf_w, 1, -1, "pos_overflow");
        cf_w[14] = 2'b00; cf_w[12] = 2'b00;
        test_stream(cf_w, 0, -1, "neg_short");
        cf_w[12] = 2'b11; cf_w[7] = 2'b10;
        test_stream(cf_w, 2, -1, "illegal_coeff");

        test_random_patterns();
        test_default_config();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
